// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding returned instruction words with their PC+4.
// Flush has priority over push and pop; a push while full is only honoured alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            doPush;
  logic            doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  assign doPush = push_i && (!full_o || pop_i);
  assign doPop  = pop_i && !empty_o;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited memory requests, prefetch FIFO, redirect handling.
// Optional FETCH_PERF_EN adds saturating bubble and redirect counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             STALL_F,
  input  logic             BRANCH_TAKEN,
  input  logic [WIDTH-1:0] BRANCH_TARGET,
  output logic             IMEM_REQ,
  output logic [WIDTH-1:0] IMEM_ADDR,
  input  logic             IMEM_RVALID,
  input  logic [WIDTH-1:0] IMEM_RDATA,
  output logic [WIDTH-1:0] INSTR_F,
  output logic [WIDTH-1:0] PCPLUS4_F,
  output logic             VALID_F
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      PERF_BUBBLE,
  output logic [31:0]      PERF_REDIRECT
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [AW-1:0]    tagWr_q, tagWr_d;
  logic [AW-1:0]    tagRd_q, tagRd_d;
  logic [WIDTH-1:0] tagMem_q [FIFO_DEPTH];

  logic             credit;
  logic             issue;
  logic             dropNow;
  logic             dataPush;
  logic             dataPop;
  fetch_entry_t     pushEntry;
  fetch_entry_t     dataHead;
  logic             dataFull;
  logic             dataEmpty;
  logic [CW-1:0]    dataCount;

  // In-flight requests (including ones marked for dropping) plus buffered words bound new requests.
  assign credit    = ({1'b0, outstanding_q} + {1'b0, dataCount}) < (CW+1)'(FIFO_DEPTH);
  assign IMEM_REQ  = credit && !BRANCH_TAKEN && !CLR;
  assign IMEM_ADDR = pc_q;
  assign issue     = IMEM_REQ;

  assign dropNow   = (drop_q != '0);
  assign dataPush  = IMEM_RVALID && !dropNow && !BRANCH_TAKEN;
  assign VALID_F   = !dataEmpty && !BRANCH_TAKEN;
  assign dataPop   = VALID_F && !STALL_F;

  assign pushEntry.instr   = XLEN'(IMEM_RDATA);
  assign pushEntry.pcplus4 = XLEN'(tagMem_q[tagRd_q]);

  assign INSTR_F   = VALID_F ? WIDTH'(dataHead.instr)   : WIDTH'(NOP_INSTR);
  assign PCPLUS4_F = VALID_F ? WIDTH'(dataHead.pcplus4) : '0;

  always_comb begin
    pc_d          = pc_q;
    drop_d        = drop_q;
    tagWr_d       = tagWr_q;
    tagRd_d       = tagRd_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(IMEM_RVALID);
    if (issue) begin
      pc_d    = pc_q + WIDTH'(PC_STEP);
      tagWr_d = tagWr_q + AW'(1);
    end
    if (IMEM_RVALID) tagRd_d = tagRd_q + AW'(1);
    // A response landing in the redirect cycle is discarded here, so it is not counted into drop.
    if (BRANCH_TAKEN) begin
      pc_d   = BRANCH_TARGET;
      drop_d = outstanding_q - CW'(IMEM_RVALID);
    end else if (IMEM_RVALID && dropNow) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      tagWr_q       <= '0;
      tagRd_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      tagWr_q       <= tagWr_d;
      tagRd_q       <= tagRd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) tagMem_q[tagWr_q] <= pc_q + WIDTH'(PC_STEP);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (CLR),
    .push_i  (dataPush),
    .data_i  (pushEntry),
    .pop_i   (dataPop),
    .flush_i (BRANCH_TAKEN),
    .head_o  (dataHead),
    .full_o  (dataFull),
    .empty_o (dataEmpty),
    .count_o (dataCount)
  );

  assert property (@(posedge CLK) disable iff (CLR) IMEM_RVALID |-> (outstanding_q != '0));
  assert property (@(posedge CLK) disable iff (CLR) dataPush |-> (!dataFull || dataPop));

`ifdef FETCH_PERF_EN
  logic [31:0] perfBubble_q;
  logic [31:0] perfRedirect_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      perfBubble_q   <= '0;
      perfRedirect_q <= '0;
    end else begin
      if (!VALID_F && !STALL_F && (perfBubble_q != '1)) perfBubble_q <= perfBubble_q + 32'd1;
      if (BRANCH_TAKEN && (perfRedirect_q != '1))       perfRedirect_q <= perfRedirect_q + 32'd1;
    end
  end

  assign PERF_BUBBLE   = perfBubble_q;
  assign PERF_REDIRECT = perfRedirect_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a variable-latency memory model feeds the stage, a monitor
// pops expected {instr, pcplus4} pairs whenever the stage hands an instruction downstream.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } expEntry_t;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        STALL_F = 1'b1;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic [31:0] INSTR_F;
  logic [31:0] PCPLUS4_F;
  logic        VALID_F;
`ifdef FETCH_PERF_EN
  logic [31:0] perfBubble;
  logic [31:0] perfRedirect;
`endif

  memReq_t   pend[$];
  expEntry_t expQ[$];
  int        errors = 0;
  int        checks = 0;
  int        cycle = 0;
  int        lat = 1;
  bit        clrReq = 1'b1;
  bit        stallReq = 1'b0;
  bit        branchReq = 1'b0;
  logic [31:0] branchTgt = '0;

  fetch_stage dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .STALL_F       (STALL_F),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_RVALID   (IMEM_RVALID),
    .IMEM_RDATA    (IMEM_RDATA),
    .INSTR_F       (INSTR_F),
    .PCPLUS4_F     (PCPLUS4_F),
    .VALID_F       (VALID_F)
`ifdef FETCH_PERF_EN
    ,
    .PERF_BUBBLE   (perfBubble),
    .PERF_REDIRECT (perfRedirect)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic beginCycle();
    @(negedge CLK);
    cycle++;
  endtask

  // Drive the cycle's inputs; downstream is held whenever nothing is expected, so no
  // instruction is consumed without a matching scoreboard entry.
  task automatic driveCycle();
    CLR           = clrReq;
    STALL_F       = stallReq || (expQ.size() == 0);
    BRANCH_TAKEN  = branchReq;
    BRANCH_TARGET = branchTgt;
    if (clrReq) pend.delete();
    if (!clrReq && pend.size() > 0 && pend[0].due <= cycle) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = pend[0].addr;
      void'(pend.pop_front());
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = 32'hDEAD_BEEF;
    end
    #1;
    if (IMEM_REQ === 1'b1) pend.push_back('{addr: IMEM_ADDR, due: cycle + lat});
  endtask

  task automatic stepCycle();
    beginCycle();
    driveCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic loadSeq(input logic [31:0] start, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      expQ.push_back('{instr: a, pc4: a + 32'd4});
    end
  endtask

  task automatic redirect(input string name, input logic [31:0] tgt, input int n);
    beginCycle();
    expQ.delete();
    if (n > 0) loadSeq(tgt, n);
    branchReq = 1'b1;
    branchTgt = tgt;
    driveCycle();
    checkOutput({name, " valid in redirect"}, 32'(VALID_F), 32'd0);
    checkOutput({name, " req in redirect"}, 32'(IMEM_REQ), 32'd0);
    branchReq = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int k = 0;
    while (expQ.size() > 0 && k < bound) begin
      stepCycle();
      k++;
    end
    checkOutput({name, " remaining"}, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: compares whatever the stage presents, independently of the stimulus flow.
  initial begin
    expEntry_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (VALID_F !== 1'b1) begin
        checkOutput("bubble instr", INSTR_F, 32'hFFFF_FFFF);
        checkOutput("bubble pcplus4", PCPLUS4_F, 32'd0);
      end else if (CLR === 1'b0 && STALL_F === 1'b0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected instr: got %h, expected none", INSTR_F);
        end else begin
          e = expQ.pop_front();
          checkOutput("instr", INSTR_F, e.instr);
          checkOutput("pcplus4", PCPLUS4_F, e.pc4);
        end
      end
    end
  end

  task automatic applyStimulus();
    // Reset held for three cycles.
    clrReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("reset req", 32'(IMEM_REQ), 32'd0);
      checkOutput("reset valid", 32'(VALID_F), 32'd0);
      checkOutput("reset instr", INSTR_F, 32'hFFFF_FFFF);
      checkOutput("reset pcplus4", PCPLUS4_F, 32'd0);
    end
    clrReq = 1'b0;
    stepCycle();
    checkOutput("first req", 32'(IMEM_REQ), 32'd1);
    checkOutput("first addr", IMEM_ADDR, 32'd0);
    checkOutput("first valid", 32'(VALID_F), 32'd0);

    // Streaming with a 1-cycle memory.
    loadSeq(32'h0, 8);
    drain("stream", 100);

    // Stall: credit fills with 0x20/0x24 and nothing more is requested.
    idle(6);
    stallReq = 1'b1;
    stepCycle();
    loadSeq(32'h20, 8);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("stall req", 32'(IMEM_REQ), 32'd0);
      checkOutput("stall valid", 32'(VALID_F), 32'd1);
      checkOutput("stall instr", INSTR_F, 32'h20);
      checkOutput("stall pcplus4", PCPLUS4_F, 32'h24);
    end
    stallReq = 1'b0;
    drain("stall resume", 100);

    // Redirect with two requests in flight on a 3-cycle memory.
    idle(6);
    lat = 3;
    redirect("pre", 32'h80, 0);
    stepCycle();
    checkOutput("pre req0 addr", IMEM_ADDR, 32'h80);
    stepCycle();
    checkOutput("pre req1 addr", IMEM_ADDR, 32'h84);
    redirect("r100", 32'h100, 4);
    drain("redirect", 100);

    // Redirect coinciding with a response, then a second redirect the next cycle.
    idle(8);
    redirect("r400", 32'h400, 0);
    idle(3);
    redirect("r500", 32'h500, 0);
    redirect("r600", 32'h600, 4);
    drain("double redirect", 100);

    // PC wrap through zero.
    lat = 1;
    idle(4);
    redirect("wrap", 32'hFFFF_FFF8, 4);
    drain("wrap", 100);
    idle(4);
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage; sits directly upstream of the fetch/decode pipeline register and drives its instruction and PC+4 inputs.
- Owns the PC register.
- Issues in-order requests to instruction memory with variable latency.
- Buffers returned words in a small prefetch FIFO.
- Handles branch redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
WIDTH, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
FIFO_DEPTH, 2, prefetch FIFO entries; also the maximum outstanding-plus-buffered count (power of 2, >=2)

Ports:
CLK  input  1  clock, rising edge
CLR  input  1  reset, asynchronous, active-high
STALL_F  input  1  downstream hold; head not consumed
BRANCH_TAKEN  input  1  redirect request
BRANCH_TARGET  input  WIDTH  redirect PC (word aligned)
IMEM_REQ  output  1  fetch request, accepted the same cycle
IMEM_ADDR  output  WIDTH  fetch address
IMEM_RVALID  input  1  response valid, in order, latency >=1
IMEM_RDATA  input  WIDTH  response instruction word
INSTR_F  output  WIDTH  instruction to the fetch/decode register
PCPLUS4_F  output  WIDTH  PC of INSTR_F plus 4
VALID_F  output  1  INSTR_F holds a real instruction

Behaviour:
- Single clock CLK; CLR asynchronous, active-high. While CLR is high:
  - PC=RESET_PC, FIFO empty, outstanding=0, drop=0.
  - IMEM_REQ=0, VALID_F=0, INSTR_F=NOP_INSTR (all ones), PCPLUS4_F=0.
- Bubble encoding: whenever VALID_F=0, INSTR_F=NOP_INSTR and PCPLUS4_F=0.
- Credit: credit = outstanding + occupancy < FIFO_DEPTH. The outstanding count includes responses marked for dropping.
- Request: IMEM_REQ=credit && !BRANCH_TAKEN && !CLR; IMEM_ADDR=PC.
  - On issue, PC<=PC+4, with modulo 2^WIDTH wrap (32'hFFFF_FFFC -> 0), and outstanding increments.
- Response: IMEM_RVALID decrements outstanding.
  - If drop>0, the word is discarded and drop decrements.
  - Otherwise {IMEM_RDATA, addr+4} is pushed. The PC of each request travels in a tag FIFO of the same depth.
  - The credit rule guarantees a push never overflows. An RVALID with outstanding=0 is illegal; assertion only.
- Output: VALID_F = FIFO non-empty && !BRANCH_TAKEN. INSTR_F/PCPLUS4_F are driven combinationally from the FIFO head.
  - Pop occurs when VALID_F && !STALL_F.
  - A push to an empty FIFO becomes visible the next cycle (no bypass), so memory-to-output latency is at least 1 cycle after RVALID.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Redirect: BRANCH_TAKEN has priority over STALL_F and a normal request.
  - Same cycle: VALID_F=0, no pop, no request.
  - Next edge: PC<=BRANCH_TARGET, FIFO flushed, drop<=outstanding minus any response arriving in the redirect cycle (that response is itself discarded).
  - Requests resume when credit is available. Stale responses are counted off via drop and never reach INSTR_F.
  - Back-to-back redirects: the last target wins; drop is recomputed each time.
- Stall: head held and outputs stable. Fetching continues until the FIFO plus in-flight count reaches FIFO_DEPTH.
- Reset mid-operation: all state cleared asynchronously. In-flight responses are not expected after reset; the memory is reset by the same CLR.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs PERF_BUBBLE (32-bit) and PERF_REDIRECT (32-bit), cleared by CLR, saturating at all ones.
  - PERF_BUBBLE counts cycles with VALID_F=0 && !STALL_F.
  - PERF_REDIRECT counts BRANCH_TAKEN cycles.
- Undefined: ports and counters absent; no area cost.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR = 32'hFFFF_FFFF
  - PC_STEP = 4
  - typedef fetch_entry_t {instr, pcplus4}
- One sub-module, fetch_fifo: parameterised depth, entries of type fetch_entry_t, push/pop/flush, full/empty/count, asynchronous CLR.
- PC, credit and drop logic stay in fetch_stage.

Test Plan:
- Reset: CLR high for 3 cycles, release -> first IMEM_ADDR=0, VALID_F=0, INSTR_F=FFFF_FFFF until the first RVALID+1.
- Streaming: 1-cycle memory returning addr as data, no stall -> VALID_F steady, INSTR_F 0,4,8..., PCPLUS4_F 4,8,12...
- Stall: STALL_F high 5 cycles -> exactly 2 requests outstanding/buffered, INSTR_F frozen, no IMEM_REQ with a full credit. Release -> sequence resumes with no loss or duplication.
- Redirect with 2 in flight: 3-cycle memory, BRANCH_TAKEN with target 0x100 -> 2 stale responses dropped, next VALID_F shows INSTR_F from 0x100, PCPLUS4_F=0x104.
- Redirect coincident with RVALID, then a second redirect the next cycle -> only the second target's instructions appear.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> addresses FFF8, FFFC, 0, 4; PCPLUS4_F=FFFC, 0, 4, 8.
